// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: MDU op codes, MDU FSM states and operand width.
package mips_pkg;
  localparam int DATA_W = 32;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } mdu_state_t;
endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign correction.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);
  assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide on
// unsigned magnitudes sharing one accumulator, with sign correction at FINISH.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int ACC_W = 2 * DATA_W;

  mdu_state_t        r_state, w_next;
  logic [4:0]        r_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0] r_a, r_b;
  logic              r_is_div, r_neg_q, r_neg_r, r_dz;

  logic              w_accept_md, w_accept_mt, w_signed, w_ge;
  logic [DATA_W-1:0] w_abs_a, w_abs_b, w_addend, w_rem_sub, w_quo, w_rem;
  logic [DATA_W:0]   w_sum, w_rem_sh;
  logic [ACC_W-1:0]  w_acc_next, w_prod;

  assign w_accept_md = start && (r_state == S_IDLE) && (op <= MDU_DIVU);
  assign w_accept_mt = start && (r_state == S_IDLE) && ((op == MDU_MTHI) || (op == MDU_MTLO));
  assign w_signed    = (op == MDU_MULT) || (op == MDU_DIV);

  mdu_sign_fix #(.W(DATA_W)) u_abs_a (
    .i_val(rs_data), .i_neg(w_signed & rs_data[DATA_W-1]), .o_val(w_abs_a));
  mdu_sign_fix #(.W(DATA_W)) u_abs_b (
    .i_val(rt_data), .i_neg(w_signed & rt_data[DATA_W-1]), .o_val(w_abs_b));
  mdu_sign_fix #(.W(ACC_W)) u_fix_prod (
    .i_val(r_acc), .i_neg(r_neg_q), .o_val(w_prod));
  mdu_sign_fix #(.W(DATA_W)) u_fix_quo (
    .i_val(r_acc[DATA_W-1:0]), .i_neg(r_neg_q), .o_val(w_quo));
  mdu_sign_fix #(.W(DATA_W)) u_fix_rem (
    .i_val(r_acc[ACC_W-1:DATA_W]), .i_neg(r_neg_r), .o_val(w_rem));

  // One iteration: multiply adds into the upper half then shifts right;
  // divide shifts the next dividend bit into the remainder (upper half) and the
  // quotient bit into the lower half. A zero divisor naturally yields an all-ones
  // quotient and the dividend as remainder.
  assign w_addend  = r_b[r_cnt] ? r_a : '0;
  assign w_sum     = {1'b0, r_acc[ACC_W-1:DATA_W]} + {1'b0, w_addend};
  assign w_rem_sh  = {r_acc[ACC_W-1:DATA_W], r_a[5'(DATA_W-1) - r_cnt]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_sub = w_rem_sh[DATA_W-1:0] - r_b;

  always_comb begin
    w_acc_next = r_acc;
    if (r_is_div)
      w_acc_next = {(w_ge ? w_rem_sub : w_rem_sh[DATA_W-1:0]), r_acc[DATA_W-2:0], w_ge};
    else
      w_acc_next = {w_sum, r_acc[DATA_W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept_md) w_next = S_RUN;
      S_RUN:    if (r_cnt == 5'd31) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 5'd0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept_md) begin
            r_cnt <= 5'd0;
          end else if (w_accept_mt) begin
            if (op == MDU_MTHI) hi <= rs_data;
            else                lo <= rs_data;
            done <= 1'b1;
          end
        end
        S_RUN: r_cnt <= r_cnt + 5'd1;
        S_FINISH: begin
          done <= 1'b1;
          if (r_is_div) begin
            hi <= w_rem;
            lo <= r_dz ? '1 : w_quo;
          end else begin
            hi <= w_prod[ACC_W-1:DATA_W];
            lo <= w_prod[DATA_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Operand/accumulator datapath carries no reset; it is always reloaded on accept.
  always_ff @(posedge clk) begin
    if (w_accept_md) begin
      r_a      <= w_abs_a;
      r_b      <= w_abs_b;
      r_acc    <= '0;
      r_is_div <= op[1];
      r_neg_q  <= w_signed & (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
      r_neg_r  <= w_signed & rs_data[DATA_W-1];
      r_dz     <= op[1] & (rt_data == '0);
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_next;
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized bench for mult_div_unit with an expected-result scoreboard.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_bad = 0;
  logic [63:0] sb[$];
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  mult_div_unit #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results from plain SystemVerilog arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] q, r;
    case (o)
      3'd0: return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      3'd1: return {32'h0, a} * {32'h0, b};
      3'd2: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      3'd3: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd4: return {a, m_lo};
      3'd5: return {m_hi, a};
      default: return {m_hi, m_lo};
    endcase
  endfunction

  task automatic push(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = model(o, a, b);
    sb.push_back(r);
    m_hi = r[63:32];
    m_lo = r[31:0];
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (reset === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("no_spurious_done", {63'b0, done}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("sb_hi", {32'h0, hi}, {32'h0, e[63:32]});
        check("sb_lo", {32'h0, lo}, {32'h0, e[31:0]});
      end
    end
  end

  task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit inj);
    logic [31:0] h0, l0;
    int cyc, bcnt;
    push(o, a, b);
    h0 = hi;
    l0 = lo;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0;
    bcnt = (busy === 1'b1) ? 1 : 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (inj && cyc == 4) begin
        start = 1'b1; op = 3'd4; rs_data = 32'hAAAA_AAAA;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (busy === 1'b1) bcnt++;
      if (cyc == 16) check("hold_hilo", {hi, lo}, {h0, l0});
    end
    check("latency", 64'(cyc), 64'd33);
    check("busy_cycles", 64'(bcnt), 64'd33);
    @(posedge clk); #1;
    check("done_drop", {63'b0, done}, 64'd0);
  endtask

  task automatic run_mt(input logic [2:0] o, input logic [31:0] a);
    push(o, a, 32'h0);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a;
    @(posedge clk); #1;
    start = 1'b0;
    check("mt_reg", {32'h0, (o == 3'd4) ? hi : lo}, {32'h0, a});
    check("mt_done", {63'b0, done}, 64'd1);
    check("mt_busy", {63'b0, busy}, 64'd0);
    @(posedge clk); #1;
    check("mt_done_drop", {63'b0, done}, 64'd0);
  endtask

  initial begin
    logic [31:0] h0, l0, ra, rb;
    logic [2:0]  ro;
    reset = 1'b1; start = 1'b0; op = 3'd0; rs_data = 32'h0; rt_data = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_state", {28'h0, busy, done, 2'b00, hi, lo}, 64'h0);

    run_md(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_md(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    check("multu", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    run_md(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md(3'd3, 32'h0000_0007, 32'h0000_0002, 1'b0);
    check("divu", {hi, lo}, 64'h0000_0001_0000_0003);
    run_md(3'd2, 32'h0000_1234, 32'h0000_0000, 1'b0);
    check("div_zero", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    run_md(3'd3, 32'h8000_0000, 32'h0000_0000, 1'b0);
    run_md(3'd2, 32'h8000_0005, 32'h0000_0000, 1'b0);

    // MTHI while a multiply is in flight must be dropped
    run_md(3'd0, 32'h1234_5678, 32'h0000_0009, 1'b1);
    check("mult_inj_hi", {32'h0, hi}, 64'h0000_0000_0000_0000);
    run_mt(3'd4, 32'hAAAA_AAAA);
    run_mt(3'd5, 32'h5555_1234);

    // invalid op in IDLE
    h0 = hi; l0 = lo;
    @(negedge clk);
    start = 1'b1; op = 3'd6; rs_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0;
    check("inv_busy", {63'b0, busy}, 64'd0);
    @(posedge clk); #1;
    check("inv_done", {63'b0, done}, 64'd0);
    check("inv_hilo", {hi, lo}, {h0, l0});

    // reset aborts a DIVU around cycle 10
    @(negedge clk);
    start = 1'b1; op = 3'd3; rs_data = 32'd100; rt_data = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    check("abort_state", {30'h0, busy, done, hi}, 64'h0);
    check("abort_lo", {32'h0, lo}, 64'h0);
    repeat (30) @(posedge clk);
    #1 check("abort_no_done", {63'b0, done}, 64'd0);
    run_md(3'd1, 32'd3, 32'd5, 1'b0);
    check("multu_3x5", {hi, lo}, 64'd15);

    // reset wins over start on the same edge
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = 3'd0; rs_data = 32'd2; rt_data = 32'd3;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    check("rst_prio_busy", {63'b0, busy}, 64'd0);
    @(posedge clk); #1;
    check("rst_prio_done", {63'b0, done}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 1) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i == 6) rb = 32'hFFFF_FFFD;
      run_md(ro, ra, rb, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1 check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
